// File: rtl/syn_bus_pkg.sv
// Shared bus definitions for the master router and its memory slaves.
package syn_bus_pkg;

  localparam int unsigned ADDR_W = 31;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  typedef enum logic [1:0] {IDLE, ACK_WAIT, RD_WAIT, DRAIN} slv_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              cmd;
    logic [DATA_W-1:0] wdata;
  } slv_req_t;

endpackage

// File: rtl/bus_slave_mem_if.sv
// Request/acknowledge/response bus between a master router port and a memory slave.
interface bus_slave_mem_if;
  import syn_bus_pkg::*;

  logic              req_i;
  logic [ADDR_W-1:0] addr_i;
  logic              cmd_i;
  logic [DATA_W-1:0] wdata_i;
  logic              stall_i;
  logic              ack_o;
  logic              resp_o;
  logic [DATA_W-1:0] rdata_o;

  modport master (
    output req_i, addr_i, cmd_i, wdata_i, stall_i,
    input  ack_o, resp_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, cmd_i, wdata_i, stall_i,
    output ack_o, resp_o, rdata_o
  );

endinterface

// File: rtl/bus_slave_mem_array.sv
// DEPTH x DATA_W storage with one synchronous write and one synchronous read port.
module bus_slave_mem_array
  import syn_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Only the read register is reset so the slave's visible rdata starts at zero
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata <= '0;
    else if (re)   rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/bus_slave_mem.sv
// Word-addressed memory slave: req/ack/resp handshake with programmable ack and read-response latency.
module bus_slave_mem
  import syn_bus_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned ACK_LAT  = 1,
  parameter int unsigned RESP_LAT = 2
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  bus_slave_mem_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned LAT_MAX = (1 << CNT_W) - 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ACK_LAT > LAT_MAX || RESP_LAT > LAT_MAX) begin : g_bad_param
    $error("bus_slave_mem: DEPTH must be a power of 2 and latencies within 0..%0d", LAT_MAX);
  end

  slv_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  slv_req_t          req_q, req_d;
  logic              ack_d, resp_d;
  logic              fire_ack_c, fire_resp_c, we_c;
  logic              cur_cmd_c;
  logic [IDX_W-1:0]  cur_idx_c;
  logic [DATA_W-1:0] cur_wdata_c;
  logic              unused_addr_c;

  // A zero-latency ack acts on the live bus; every later state uses the latched copy
  assign cur_cmd_c     = (state_q == IDLE) ? bus.cmd_i                : req_q.cmd;
  assign cur_idx_c     = (state_q == IDLE) ? bus.addr_i[IDX_W-1:0]    : req_q.addr[IDX_W-1:0];
  assign cur_wdata_c   = (state_q == IDLE) ? bus.wdata_i              : req_q.wdata;
  assign we_c          = fire_ack_c && (cur_cmd_c == CMD_WR);
  assign unused_addr_c = ^{bus.addr_i[ADDR_W-1:IDX_W], req_q.addr[ADDR_W-1:IDX_W]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      bus.ack_o  <= 1'b0;
      bus.resp_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      bus.ack_o  <= ack_d;
      bus.resp_o <= resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    ack_d       = 1'b0;
    resp_d      = 1'b0;
    fire_ack_c  = 1'b0;
    fire_resp_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          req_d = '{addr: bus.addr_i, cmd: bus.cmd_i, wdata: bus.wdata_i};
          if (ACK_LAT == 0) begin
            fire_ack_c = 1'b1;
          end else begin
            cnt_d   = CNT_W'(ACK_LAT);
            state_d = ACK_WAIT;
          end
        end
      end
      ACK_WAIT: begin
        if (!bus.req_i) begin
          state_d = IDLE;
        end else if (!bus.stall_i) begin
          if (cnt_q == CNT_W'(1)) fire_ack_c = 1'b1;
          else                    cnt_d      = cnt_q - CNT_W'(1);
        end
      end
      RD_WAIT: begin
        if (!bus.req_i) begin
          state_d = IDLE;
        end else if (!bus.stall_i) begin
          if (cnt_q == CNT_W'(1)) fire_resp_c = 1'b1;
          else                    cnt_d       = cnt_q - CNT_W'(1);
        end
      end
      DRAIN: begin
        // Hold off until the master drops its stale request
        if (!bus.req_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fire_ack_c) begin
      ack_d = 1'b1;
      if (cur_cmd_c == CMD_WR) begin
        state_d = DRAIN;
      end else if (RESP_LAT == 0) begin
        fire_resp_c = 1'b1;
      end else begin
        cnt_d   = CNT_W'(RESP_LAT);
        state_d = RD_WAIT;
      end
    end

    if (fire_resp_c) begin
      resp_d  = 1'b1;
      state_d = DRAIN;
    end
  end

  bus_slave_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we      (we_c),
    .waddr   (cur_idx_c),
    .wdata   (cur_wdata_c),
    .re      (fire_resp_c),
    .raddr   (cur_idx_c),
    .rdata   (bus.rdata_o)
  );

  // The master must hold req_i until ack (write) or resp (read)
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q inside {ACK_WAIT, RD_WAIT}) |-> bus.req_i)
    else $warning("bus_slave_mem: req_i dropped before completion, transaction aborted");

endmodule

// File: tb/tb_bus_slave_mem.sv
// Self-checking bench for bus_slave_mem: directed vectors, corner sequences and a randomized run.
module tb_bus_slave_mem;
  import syn_bus_pkg::*;

  localparam int unsigned D_ACK  = 1;
  localparam int unsigned D_RESP = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_slave_mem_if ifd();
  bus_slave_mem_if ifz();

  bus_slave_mem #(.DEPTH(256), .ACK_LAT(D_ACK), .RESP_LAT(D_RESP)) dut_d (
    .clk_i(clk), .rst_n_i(rst_n), .bus(ifd.slave));
  bus_slave_mem #(.DEPTH(256), .ACK_LAT(0), .RESP_LAT(0)) dut_z (
    .clk_i(clk), .rst_n_i(rst_n), .bus(ifz.slave));

  typedef struct {
    bit          z;
    logic        cmd;
    logic [30:0] addr;
    logic [31:0] wdata;
    logic [63:0] stall_v;
    int          exp_ack;
    int          exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mdl [2][256];
  bit          vld [2][256];
  vec_t        vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit z, input logic req, input logic cmd, input logic [30:0] addr,
                       input logic [31:0] wd, input logic stall);
    if (z) begin
      ifz.req_i = req; ifz.cmd_i = cmd; ifz.addr_i = addr; ifz.wdata_i = wd; ifz.stall_i = stall;
    end else begin
      ifd.req_i = req; ifd.cmd_i = cmd; ifd.addr_i = addr; ifd.wdata_i = wd; ifd.stall_i = stall;
    end
  endtask

  task automatic sample(input bit z, output logic ack, output logic resp, output logic [31:0] rd);
    if (z) begin ack = ifz.ack_o; resp = ifz.resp_o; rd = ifz.rdata_o; end
    else   begin ack = ifd.ack_o; resp = ifd.resp_o; rd = ifd.rdata_o; end
  endtask

  // First edge after 'start' by which 'lat' unstalled edges have elapsed
  function automatic int exp_tick(input logic [63:0] sv, input int start, input int lat);
    int c = 0;
    if (lat == 0) return start;
    for (int e = start + 1; e < 62; e++) begin
      if (!sv[e]) c++;
      if (c == lat) return e;
    end
    return -1;
  endfunction

  // One master transaction; ticks counted from the edge that first samples req
  task automatic run_txn(input bit z, input logic cmd, input logic [30:0] addr, input logic [31:0] wd,
                         input logic [63:0] sv, input int hold, input bit scramble,
                         output int ack_n, output int resp_n, output int acks, output int resps,
                         output logic [31:0] rd);
    logic a, r, req_l, cmd_l;
    logic [31:0] d, wd_l;
    logic [30:0] addr_l;
    int done_n;
    ack_n = -1; resp_n = -1; acks = 0; resps = 0; rd = '0; done_n = -1;
    req_l = 1'b1; cmd_l = cmd; addr_l = addr; wd_l = wd;
    drive(z, req_l, cmd_l, addr_l, wd_l, sv[1]);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      sample(z, a, r, d);
      if (a) begin acks++;  if (ack_n < 0) ack_n = n; end
      if (r) begin resps++; if (resp_n < 0) begin resp_n = n; rd = d; end end
      if (done_n < 0 && ((cmd == CMD_WR) ? (ack_n > 0) : (resp_n > 0))) done_n = n;
      if (done_n > 0 && n == done_n + hold) req_l = 1'b0;
      if (done_n > 0 && n == done_n + hold + 2) break;
      if (scramble) begin addr_l = 31'($urandom); wd_l = $urandom; cmd_l = 1'($urandom); end
      drive(z, req_l, cmd_l, addr_l, wd_l, sv[n+1]);
    end
    drive(z, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic check_txn(input string tag, input bit z, input logic cmd, input logic [30:0] addr,
                           input logic [31:0] wd, input logic [63:0] sv, input int eack, input int eresp,
                           input logic [31:0] erd, input int hold, input bit scramble);
    int ack_n, resp_n, acks, resps;
    logic [31:0] rd;
    run_txn(z, cmd, addr, wd, sv, hold, scramble, ack_n, resp_n, acks, resps, rd);
    check($sformatf("%s.ack_at", tag), 64'(ack_n), 64'(eack));
    check($sformatf("%s.acks", tag), 64'(acks), 64'd1);
    check($sformatf("%s.resp_at", tag), 64'(resp_n), 64'(eresp));
    check($sformatf("%s.resps", tag), 64'(resps), (cmd == CMD_RD) ? 64'd1 : 64'd0);
    if (cmd == CMD_RD) check($sformatf("%s.rdata", tag), 64'(rd), 64'(erd));
  endtask

  initial begin
    int cnt_a, cnt_r;
    bit          rz;
    logic        rcmd;
    logic [30:0] raddr;
    logic [7:0]  rix;
    logic [31:0] rwd;
    logic [63:0] rsv;
    int          eack, eresp, la, lr;

    vecs[0]  = '{0, CMD_WR, 31'h005, 32'hDEADBEEF, 64'h0,   2, -1, 32'h0};
    vecs[1]  = '{0, CMD_RD, 31'h005, 32'h0,        64'h0,   2,  4, 32'hDEADBEEF};
    vecs[2]  = '{1, CMD_WR, 31'h005, 32'hDEADBEEF, 64'h0,   1, -1, 32'h0};
    vecs[3]  = '{1, CMD_RD, 31'h005, 32'h0,        64'h0,   1,  1, 32'hDEADBEEF};
    vecs[4]  = '{0, CMD_WR, 31'h001, 32'h11,       64'h0,   2, -1, 32'h0};
    vecs[5]  = '{0, CMD_WR, 31'h002, 32'h22,       64'h0,   2, -1, 32'h0};
    vecs[6]  = '{0, CMD_RD, 31'h001, 32'h0,        64'h0,   2,  4, 32'h11};
    vecs[7]  = '{0, CMD_RD, 31'h002, 32'h0,        64'h0,   2,  4, 32'h22};
    vecs[8]  = '{0, CMD_WR, 31'h003, 32'hCAFE0003, 64'h1C,  5, -1, 32'h0};
    vecs[9]  = '{0, CMD_RD, 31'h003, 32'h0,        64'h1DC, 5, 10, 32'hCAFE0003};
    vecs[10] = '{0, CMD_WR, 31'h004, 32'h44,       64'h2,   2, -1, 32'h0};
    vecs[11] = '{0, CMD_RD, 31'h004, 32'h0,        64'h2,   2,  4, 32'h44};
    vecs[12] = '{1, CMD_RD, 31'h005, 32'h0,        64'hE,   1,  1, 32'hDEADBEEF};
    vecs[13] = '{0, CMD_WR, 31'h105, 32'h77,       64'h0,   2, -1, 32'h0};
    vecs[14] = '{0, CMD_RD, 31'h005, 32'h0,        64'h0,   2,  4, 32'h77};

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset.d.ack", 64'(ifd.ack_o), 64'd0);
    check("reset.d.resp", 64'(ifd.resp_o), 64'd0);
    check("reset.d.rdata", 64'(ifd.rdata_o), 64'd0);
    check("reset.z.ack", 64'(ifz.ack_o), 64'd0);
    check("reset.z.resp", 64'(ifz.resp_o), 64'd0);
    check("reset.z.rdata", 64'(ifz.rdata_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      check_txn($sformatf("vec%0d", i), vecs[i].z, vecs[i].cmd, vecs[i].addr, vecs[i].wdata,
                vecs[i].stall_v, vecs[i].exp_ack, vecs[i].exp_resp, vecs[i].exp_rdata, 1, 0);

    // Request held long after ack must not be re-accepted
    check_txn("hold.wr", 0, CMD_WR, 31'h006, 32'h66, 64'h0, 2, -1, 32'h0, 6, 0);
    check_txn("hold.rd", 0, CMD_RD, 31'h006, 32'h0,  64'h0, 2,  4, 32'h66, 6, 0);

    // req dropped in ACK_WAIT: no ack, write not performed
    drive(0, 1'b1, CMD_WR, 31'h105, 32'h99, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, CMD_WR, 31'h105, 32'h99, 1'b0);
    cnt_a = 0;
    for (int n = 0; n < 5; n++) begin @(posedge clk); #1; if (ifd.ack_o) cnt_a++; end
    check("abort_ack.acks", 64'(cnt_a), 64'd0);
    check_txn("abort_ack.read", 0, CMD_RD, 31'h005, 32'h0, 64'h0, 2, 4, 32'h77, 1, 0);

    // req dropped in RD_WAIT: no resp, rdata holds previous value
    drive(0, 1'b1, CMD_RD, 31'h003, 32'h0, 1'b0);
    cnt_a = 0; cnt_r = 0;
    for (int n = 0; n < 2; n++) begin @(posedge clk); #1; if (ifd.ack_o) cnt_a++; end
    drive(0, 1'b0, CMD_RD, 31'h003, 32'h0, 1'b0);
    for (int n = 0; n < 5; n++) begin @(posedge clk); #1; if (ifd.resp_o) cnt_r++; end
    check("abort_rd.acks", 64'(cnt_a), 64'd1);
    check("abort_rd.resps", 64'(cnt_r), 64'd0);
    check("abort_rd.rdata", 64'(ifd.rdata_o), 64'h77);

    // Reset during RD_WAIT
    drive(0, 1'b1, CMD_RD, 31'h005, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(0, 1'b0, CMD_RD, 31'h005, 32'h0, 1'b0);
    #2;
    check("rst_mid.ack", 64'(ifd.ack_o), 64'd0);
    check("rst_mid.resp", 64'(ifd.resp_o), 64'd0);
    check("rst_mid.rdata", 64'(ifd.rdata_o), 64'd0);
    check("rst_mid.z.rdata", 64'(ifz.rdata_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt_a = 0; cnt_r = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (ifd.ack_o) cnt_a++;
      if (ifd.resp_o) cnt_r++;
    end
    check("rst_mid.late_acks", 64'(cnt_a), 64'd0);
    check("rst_mid.late_resps", 64'(cnt_r), 64'd0);
    check_txn("rst_mid.new_read", 0, CMD_RD, 31'h001, 32'h0, 64'h0, 2, 4, 32'h11, 1, 0);

    // Randomized transactions with random stalls against a word-indexed reference memory
    for (int t = 0; t < 40; t++) begin
      rz    = ($urandom_range(0, 3) == 0);
      raddr = 31'($urandom);
      rix   = raddr[7:0];
      rcmd  = 1'($urandom);
      rwd   = $urandom;
      rsv   = {$urandom, $urandom} & {$urandom, $urandom};
      la    = rz ? 0 : int'(D_ACK);
      lr    = rz ? 0 : int'(D_RESP);
      if (rcmd == CMD_RD && !vld[rz][rix]) rcmd = CMD_WR;
      eack  = exp_tick(rsv, 1, la);
      eresp = (rcmd == CMD_RD) ? exp_tick(rsv, eack, lr) : -1;
      check_txn($sformatf("rnd%0d", t), rz, rcmd, raddr, rwd, rsv, eack, eresp, mdl[rz][rix],
                $urandom_range(1, 3), 1);
      if (rcmd == CMD_WR) begin
        mdl[rz][rix] = rwd;
        vld[rz][rix] = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
